sdft_sequencer: RTL
===================

// Module: sdft_sequencer
// PURPOSE
// Front-end controller for the sliding-DFT core. Captures ADC samples into a small
// FIFO and feeds them one at a time to the SDFT over its start/ready handshake.
// Absorbs ADC samples that arrive while a bin update is in progress.
// Counts dropped samples and flags when a full window has been processed.
// PARAMETERS
// data_width  8   sample width, two's complement; matches the SDFT data_width
// freq_bins   16  SDFT window length; sets the window_full threshold
// fifo_depth  4   sample FIFO entries; must be a power of two, >= 2
// PORTS
// clk            in   1                  system clock, all logic on rising edge
// reset          in   1                  asynchronous, active-high; clears all state
// adc_sample     in   data_width         signed sample from the ADC
// adc_valid      in   1                  one-cycle strobe: adc_sample is valid
// clear_overrun  in   1                  synchronous clear of overrun and drop_count
// sdft_sample    out  data_width         sample presented to the SDFT; registered
// sdft_start     out  1                  one-cycle pulse requesting an SDFT update
// sdft_ready     in   1                  SDFT idle and able to accept start
// fifo_level     out  clog2(depth)+1     current FIFO occupancy, 0..fifo_depth
// overrun        out  1                  sticky: at least one sample was dropped
// drop_count     out  8                  dropped samples, saturates at 255
// window_full    out  1                  sticky: >= freq_bins samples fully processed
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; FIFO flushed; level=0.
//   sdft_start=0, sdft_sample=0, overrun=0, drop_count=0, window_full=0.
//   The processed counter is also cleared.
// - FIFO push: when adc_valid=1 and (level<fifo_depth, or a pop occurs the same cycle).
//   adc_valid=1 with level==fifo_depth and no pop: sample discarded, overrun<=1.
//   In the same case drop_count<=drop_count+1, saturating at 255.
// - FIFO pop: occurs only on the IDLE->ISSUE transition. The head entry is loaded
//   into sdft_sample. Push and pop in the same cycle leave level unchanged.
// - A sample pushed in cycle N is not poppable before cycle N+1 (registered level).
// - clear_overrun=1 zeroes overrun and drop_count. If a drop occurs in the same
//   cycle, the drop wins: overrun=1, drop_count=1.
// - FSM, four states:
//   IDLE:  if level>0 and sdft_ready=1 -> pop, go to ISSUE; else stay.
//   ISSUE: sdft_start=1 for exactly this cycle -> ARMED.
//   ARMED: wait for sdft_ready=0, i.e. the SDFT has accepted -> BUSY.
//   BUSY:  wait for sdft_ready=1. Then processed count +1 (saturating at freq_bins) -> IDLE.
// - sdft_sample is held constant from ISSUE until the next pop. The SDFT samples it
//   the cycle after start.
// - Latency: with FIFO empty, FSM in IDLE, and SDFT ready, adc_valid at cycle N
//   gives sdft_start=1 in cycle N+2.
// - Back-to-back throughput: one issue per SDFT busy period plus 2 cycles
//   (ISSUE, plus the IDLE re-check).
// - window_full is set in the cycle the processed count reaches freq_bins. It then
//   stays set until reset.
// - sdft_start is decoded from the state register, so it is glitch-free and never
//   asserted outside ISSUE.
// - Reset mid-operation, in ARMED or BUSY: the FIFO and pending sample are lost.
//   The FSM returns to IDLE and issues nothing until sdft_ready=1. The SDFT is not
//   reset by this block.
// - sdft_ready dropping in IDLE is legal. The FSM simply waits for it to return.
// TESTING
// - Single sample: SDFT model ready; adc_valid with 0x35 at cycle 10.
//   Expect sdft_start at cycle 12 with sdft_sample=0x35. level returns to 0 at cycle 12.
// - Burst: 4 strobes on consecutive cycles (0x01..0x04) while the SDFT model is busy
//   for 40 cycles. Expect level=4 and overrun=0.
//   Then expect 4 starts in order 0x01..0x04, each only after sdft_ready rises.
// - Overflow: 6 strobes while busy. Expect level=4, overrun=1, drop_count=2.
//   clear_overrun then gives overrun=0, drop_count=0.
// - Saturation: 300 strobes with the SDFT held busy. Expect drop_count=255, not wrapped.
// - Window: feed 16 samples through an SDFT model. Expect window_full=0 after the
//   15th ready return and 1 after the 16th. It stays 1 after further samples.
// - Reset during BUSY: assert reset for 1 cycle with level=3. Expect all outputs 0.
//   Hold sdft_ready=0 for 20 cycles: no start. Raise ready with no new samples:
//   still no start.

Source files
------------

// File: rtl/sdft_sequencer_if.sv
// -----------------------------------------------------------------------------
// sdft_sequencer_if
// Groups the sample path of the SDFT front end: the ADC strobe/sample input and
// the start/ready handshake towards the sliding-DFT core.
//   adc_sample  : signed ADC sample, qualified by adc_valid
//   adc_valid   : one-cycle strobe
//   sdft_sample : sample presented to the SDFT core
//   sdft_start  : one-cycle update request to the SDFT core
//   sdft_ready  : SDFT core idle and able to accept a start
// master : the sequencer side; slave : the ADC/SDFT environment side.
// -----------------------------------------------------------------------------
interface sdft_sequencer_if #(
  parameter int data_width = 8
);
  logic signed [data_width-1:0] adc_sample;
  logic                         adc_valid;
  logic        [data_width-1:0] sdft_sample;
  logic                         sdft_start;
  logic                         sdft_ready;

  modport master (
    input  adc_sample, adc_valid, sdft_ready,
    output sdft_sample, sdft_start
  );

  modport slave (
    output adc_sample, adc_valid, sdft_ready,
    input  sdft_sample, sdft_start
  );
endinterface

// File: rtl/sdft_sequencer.sv
// -----------------------------------------------------------------------------
// sdft_sequencer
// Front-end controller for the sliding-DFT core. ADC samples are captured into
// a small FIFO and handed one at a time to the SDFT over start/ready. Samples
// arriving with a full FIFO are dropped and counted; a sticky flag reports once
// freq_bins samples have been fully processed.
// Ports:
//   clk           : system clock, rising edge
//   reset         : asynchronous, active-high
//   bus           : ADC input and SDFT handshake (sdft_sequencer_if.master)
//   clear_overrun : synchronous clear of overrun and drop_count
//   fifo_level    : FIFO occupancy, 0..fifo_depth
//   overrun       : sticky, at least one sample dropped
//   drop_count    : dropped samples, saturating at 255
//   window_full   : sticky, freq_bins samples processed since reset
// -----------------------------------------------------------------------------
module sdft_sequencer #(
  parameter int data_width = 8,
  parameter int freq_bins  = 16,
  parameter int fifo_depth = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  sdft_sequencer_if.master                  bus,
  input  logic                              clear_overrun,
  output logic [$clog2(fifo_depth):0]       fifo_level,
  output logic                              overrun,
  output logic [7:0]                        drop_count,
  output logic                              window_full
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int lvl_w = ptr_w + 1;
  localparam int cnt_w = $clog2(freq_bins + 1);

  localparam logic [lvl_w-1:0] lvl_zero = {lvl_w{1'b0}};
  localparam logic [lvl_w-1:0] lvl_full = lvl_w'(fifo_depth);
  localparam logic [lvl_w-1:0] lvl_one  = lvl_w'(1);
  localparam logic [ptr_w-1:0] ptr_one  = ptr_w'(1);
  localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(freq_bins);
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARMED = 2'd2,
    BUSY  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [data_width-1:0]  mem_q [fifo_depth];
  logic [data_width-1:0]  mem_d [fifo_depth];
  logic [ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
  logic [lvl_w-1:0]       level_q, level_d;
  logic [data_width-1:0]  sample_q, sample_d;
  logic                   start_q, start_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             drop_q, drop_d;
  logic [cnt_w-1:0]       processed_q, processed_d;
  logic                   window_full_q, window_full_d;

  logic pop;
  logic push;
  logic drop;

  // Next-state logic: FIFO bookkeeping, drop accounting and the issue FSM.
  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    sample_d      = sample_q;
    overrun_d     = overrun_q;
    drop_d        = drop_q;
    processed_d   = processed_q;

    // Pop only on IDLE->ISSUE; level is registered, so a sample pushed this
    // cycle cannot be popped until the next one.
    pop  = (state_q == IDLE) && (level_q != lvl_zero) && bus.sdft_ready;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    push = bus.adc_valid && ((level_q != lvl_full) || pop);
    drop = bus.adc_valid && !push;

    if (push) begin
      mem_d[wr_ptr_q] = bus.adc_sample;
      wr_ptr_d        = wr_ptr_q + ptr_one;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop) begin
      sample_d = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + ptr_one;
    end else begin
      sample_d = sample_q;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + lvl_one;
      2'b01:   level_d = level_q - lvl_one;
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear wins and restarts the count at 1.
    if (drop && clear_overrun) begin
      overrun_d = 1'b1;
      drop_d    = 8'd1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
      drop_d    = 8'd0;
    end else if (drop) begin
      overrun_d = 1'b1;
      drop_d    = (drop_q == 8'd255) ? drop_q : (drop_q + 8'd1);
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = ARMED;
      end
      ARMED: begin
        // ready falling means the SDFT has taken the start
        if (!bus.sdft_ready) begin
          state_d = BUSY;
        end else begin
          state_d = ARMED;
        end
      end
      BUSY: begin
        if (bus.sdft_ready) begin
          state_d     = IDLE;
          processed_d = (processed_q == cnt_max) ? processed_q : (processed_q + cnt_one);
        end else begin
          state_d     = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // start is a registered decode of the next state, so it is high exactly
    // while the state register holds ISSUE.
    start_d       = (state_d == ISSUE);
    window_full_d = window_full_q || (processed_d == cnt_max);
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      for (int i = 0; i < fifo_depth; i++) begin
        mem_q[i] <= {data_width{1'b0}};
      end
      wr_ptr_q      <= {ptr_w{1'b0}};
      rd_ptr_q      <= {ptr_w{1'b0}};
      level_q       <= lvl_zero;
      sample_q      <= {data_width{1'b0}};
      start_q       <= 1'b0;
      overrun_q     <= 1'b0;
      drop_q        <= 8'd0;
      processed_q   <= {cnt_w{1'b0}};
      window_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      sample_q      <= sample_d;
      start_q       <= start_d;
      overrun_q     <= overrun_d;
      drop_q        <= drop_d;
      processed_q   <= processed_d;
      window_full_q <= window_full_d;
    end
  end

  assign bus.sdft_sample = sample_q;
  assign bus.sdft_start  = start_q;
  assign fifo_level      = level_q;
  assign overrun         = overrun_q;
  assign drop_count      = drop_q;
  assign window_full     = window_full_q;

endmodule
